// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache between the PC and the
// F/D register. A hit returns InstrF in the same cycle. A miss stalls the front
// end and refills one line from backing memory as a burst of word beats.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   req, PCF          fetch request and fetch address (PCF[1:0] ignored)
//   inv               invalidate every line (fence.i / flush)
//   InstrF, hit       fetched instruction, valid while hit=1
//   stall             front-end stall, ORed into the hazard unit's stall
//   mem_req           one-cycle refill request pulse
//   mem_addr          line-aligned refill address, held for the whole refill
//   mem_rdata         refill data beat
//   mem_rvalid        refill beat valid
//   hit_count         32-bit hit counter, wraps
//   miss_count        32-bit miss counter, wraps
//   dbg_state         current FSM state (0 = IDLE, 1 = REFILL)
//
// Handshake: mem_req pulses high for one cycle to start a refill. There is no
// ready signal on the return path. The cache accepts every mem_rvalid beat
// while in REFILL, in order, word 0 first. It ignores beats while in IDLE.
module icache_dm #(
  parameter int WIDTH = 32,
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [WIDTH-1:0] PCF,
  input  logic             inv,
  output logic [WIDTH-1:0] InstrF,
  output logic             hit,
  output logic             stall,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_rvalid,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count,
  output logic [0:0]       dbg_state
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = WIDTH - IDX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);
  localparam logic [OFF_W-1:0] BEAT_ONE  = OFF_W'(1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t             state;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [WIDTH-1:0]   data_mem [LINES][WORDS];
  logic [OFF_W-1:0]   beat;
  logic [TAG_W-1:0]   r_tag;
  logic [IDX_W-1:0]   r_idx;
  logic               inv_pending;

  logic [OFF_W-1:0]   offset;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               last_beat;
  logic               unused_pcf;

  assign offset     = PCF[OFF_W+1:2];
  assign idx        = PCF[OFF_W+2+IDX_W-1:OFF_W+2];
  assign tag        = PCF[WIDTH-1:OFF_W+2+IDX_W];
  assign unused_pcf = ^PCF[1:0];

  // Combinational lookup. The valid bits and tags seen here are the values
  // from before the edge, so an inv in IDLE does not affect this cycle's hit.
  assign hit       = req && valid[idx] && (tag_mem[idx] == tag) && (state == IDLE);
  assign InstrF    = (state == IDLE) ? data_mem[idx][offset] : '0;
  assign stall     = (req && !hit) || (state != IDLE);
  assign dbg_state = state;
  assign last_beat = (state == REFILL) && mem_rvalid && (beat == LAST_BEAT);

  // Control state: FSM, valid bits, refill registers and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      valid       <= '0;
      beat        <= '0;
      r_tag       <= '0;
      r_idx       <= '0;
      inv_pending <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      mem_req <= 1'b0;
      case (state)
        IDLE: begin
          if (inv) valid <= '0;
          if (req && !hit) begin
            // The invalidate, if any, applies before this refill. The new
            // line is therefore validated normally when the refill completes.
            r_tag       <= tag;
            r_idx       <= idx;
            mem_addr    <= {tag, idx, {(OFF_W + 2){1'b0}}};
            mem_req     <= 1'b1;
            valid[idx]  <= 1'b0;
            beat        <= '0;
            inv_pending <= 1'b0;
            miss_count  <= miss_count + 32'd1;
            state       <= REFILL;
          end else if (req && hit) begin
            hit_count <= hit_count + 32'd1;
          end
        end
        REFILL: begin
          if (inv) begin
            valid       <= '0;
            inv_pending <= 1'b1;
          end
          if (mem_rvalid) begin
            beat <= beat + BEAT_ONE;
            if (beat == LAST_BEAT) begin
              // An invalidate seen at any point in this refill, including
              // this cycle, keeps the line invalid.
              valid[r_idx] <= !(inv_pending || inv);
              inv_pending  <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage has no reset. It is only visible through a set valid bit.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_rvalid) begin
      data_mem[r_idx][beat] <= mem_rdata;
      if (last_beat) tag_mem[r_idx] <= r_tag;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed testbench for icache_dm with LINES=16 and WORDS=4. Inputs are
// driven at the falling edge. Outputs are sampled at the falling edge.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] PCF;
  logic        inv;
  logic [31:0] InstrF;
  logic        hit;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic [0:0]  dbg_state;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_hits   = 32'd0;
  logic [31:0] exp_misses = 32'd0;
  logic [31:0] exp_q[$];

  // Clock and reset
  always #5 clk = ~clk;

  icache_dm #(.WIDTH(32), .LINES(16), .WORDS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .PCF        (PCF),
    .inv        (inv),
    .InstrF     (InstrF),
    .hit        (hit),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .dbg_state  (dbg_state)
  );

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Driver tasks
  // Present a missing address, take the miss edge, and check the request pulse.
  task automatic miss_start(input logic [31:0] addr, input logic with_inv);
    req = 1'b1;
    PCF = addr;
    inv = with_inv;
    #1;
    check("miss_hit", {31'd0, hit}, 32'd0);
    check("miss_stall", {31'd0, stall}, 32'd1);
    tick();
    inv = 1'b0;
    exp_misses++;
    check("mem_req_pulse", {31'd0, mem_req}, 32'd1);
    check("mem_addr", mem_addr, addr & ~32'hF);
    check("state_refill", {31'd0, dbg_state}, 32'd1);
    check("miss_count", miss_count, exp_misses);
  endtask

  // Feed n slots of beat data. pat[i] is the rvalid value for slot i.
  // inv is raised in slot inv_slot. PCF shows mid_pcf during the burst.
  task automatic feed(input logic [31:0] base, input logic [6:0] pat, input int n,
                      input logic [31:0] line_addr, input logic [31:0] mid_pcf,
                      input int inv_slot, input logic [31:0] restore_pcf);
    int beat_n = 0;
    for (int i = 0; i < n; i++) begin
      mem_rvalid = pat[i];
      mem_rdata  = pat[i] ? base + beat_n : 32'hDEAD_BEEF;
      inv        = (i == inv_slot);
      PCF        = mid_pcf;
      #1;
      check("refill_stall", {31'd0, stall}, 32'd1);
      check("refill_addr_hold", mem_addr, line_addr);
      if (i > 0) check("mem_req_once", {31'd0, mem_req}, 32'd0);
      tick();
      if (pat[i]) beat_n++;
    end
    mem_rvalid = 1'b0;
    inv        = 1'b0;
    PCF        = restore_pcf;
  endtask

  task automatic lookup_hit(input logic [31:0] addr, input logic [31:0] exp_data);
    req = 1'b1;
    PCF = addr;
    #1;
    check("lookup_hit", {31'd0, hit}, 32'd1);
    check("lookup_instr", InstrF, exp_data);
    check("lookup_stall", {31'd0, stall}, 32'd0);
    tick();
    exp_hits++;
    check("hit_count", hit_count, exp_hits);
    check("no_mem_req", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    rst        = 1'b0;
    req        = 1'b1;
    PCF        = 32'h10;
    inv        = 1'b0;
    mem_rdata  = 32'd0;
    mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hit", {31'd0, hit}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd1);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);
    rst = 1'b1;

    // 1: cold miss
    miss_start(32'h10, 1'b0);
    feed(32'hA0, 7'b0001111, 4, 32'h10, 32'h10, -1, 32'h10);
    check("s1_idle", {31'd0, dbg_state}, 32'd0);
    lookup_hit(32'h10, 32'hA0);
    check("s1_miss_count", miss_count, 32'd1);

    // 2: spatial hits
    for (int i = 1; i < 4; i++) exp_q.push_back(32'hA0 + i);
    for (int i = 1; i < 4; i++) lookup_hit(32'h10 + 4 * i, exp_q.pop_front());
    check("s2_hit_total", hit_count, 32'd4);

    // 3: conflict eviction
    miss_start(32'h110, 1'b0);
    feed(32'hB0, 7'b0001111, 4, 32'h110, 32'h110, -1, 32'h110);
    lookup_hit(32'h110, 32'hB0);
    miss_start(32'h10, 1'b0);
    feed(32'hA0, 7'b0001111, 4, 32'h10, 32'h10, -1, 32'h10);
    lookup_hit(32'h10, 32'hA0);

    // 4: invalidate during refill, raised after beat 1
    miss_start(32'h20, 1'b0);
    feed(32'hE0, 7'b0001111, 4, 32'h20, 32'h20, 2, 32'h20);
    check("s4_idle", {31'd0, dbg_state}, 32'd0);
    #1;
    check("s4_0x20_miss", {31'd0, hit}, 32'd0);
    PCF = 32'h10;
    #1;
    check("s4_0x10_miss", {31'd0, hit}, 32'd0);
    req = 1'b0;
    #1;
    check("s4_no_req_stall", {31'd0, stall}, 32'd0);

    // 5: gapped beats, PCF moved mid-refill
    miss_start(32'h20, 1'b0);
    feed(32'hC0, 7'b1011001, 7, 32'h20, 32'h40, -1, 32'h20);
    check("s5_idle", {31'd0, dbg_state}, 32'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hC0 + i);
    for (int i = 0; i < 4; i++) lookup_hit(32'h20 + 4 * i, exp_q.pop_front());
    // inv in IDLE: this cycle still hits, the next one does not
    req = 1'b1;
    PCF = 32'h24;
    inv = 1'b1;
    #1;
    check("idle_inv_same_cycle_hit", {31'd0, hit}, 32'd1);
    check("idle_inv_same_cycle_instr", InstrF, 32'hC1);
    tick();
    exp_hits++;
    inv = 1'b0;
    #1;
    check("idle_inv_after_miss", {31'd0, hit}, 32'd0);
    check("idle_inv_hit_count", hit_count, exp_hits);

    // 6: reset mid-refill, then counter wrap
    miss_start(32'h30, 1'b0);
    feed(32'hF0, 7'b0000011, 2, 32'h30, 32'h30, -1, 32'h30);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hF2;
    rst        = 1'b0;
    #1;
    exp_hits   = 32'd0;
    exp_misses = 32'd0;
    check("s6_rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("s6_rst_mem_addr", mem_addr, 32'd0);
    check("s6_rst_hit_count", hit_count, 32'd0);
    check("s6_rst_miss_count", miss_count, 32'd0);
    check("s6_rst_state", {31'd0, dbg_state}, 32'd0);
    check("s6_rst_stall", {31'd0, stall}, 32'd1);
    tick();
    req = 1'b0;
    rst = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    check("s6_stray_beat_idle", {31'd0, dbg_state}, 32'd0);
    req = 1'b1;
    PCF = 32'h30;
    #1;
    check("s6_0x30_invalid", {31'd0, hit}, 32'd0);
    // miss together with inv: the new line must still be validated
    miss_start(32'h20, 1'b1);
    feed(32'hD0, 7'b0001111, 4, 32'h20, 32'h20, -1, 32'h20);
    lookup_hit(32'h20, 32'hD0);
    dut.hit_count = 32'hFFFF_FFFF;
    exp_hits      = 32'hFFFF_FFFF;
    lookup_hit(32'h24, 32'hD1);
    check("s6_wrap_zero", hit_count, 32'd0);
    req = 1'b0;

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache placed between program_counter (PCF) and the F/D pipeline register.
- Replaces the direct instruction_memory lookup; on a hit it returns InstrF in the same cycle.
- On a miss it stalls the front end and refills one line from backing memory using a burst of word beats.
- Provides hit/miss performance counters.

Parameters:
- WIDTH, 32, data/address width.
- LINES, 16, number of cache lines (power of 2).
- WORDS, 4, 32-bit words per line (power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  fetch request valid this cycle.
- PCF  in  WIDTH  fetch address; bits [1:0] ignored.
- inv  in  1  invalidate all lines (fence.i / flush).
- InstrF  out  WIDTH  fetched instruction; valid when hit=1.
- hit  out  1  req && lookup hit && FSM in IDLE.
- stall  out  1  front-end stall, ORed into the hazard unit's stall.
- mem_req  out  1  one-cycle line-refill request pulse.
- mem_addr  out  WIDTH  line-aligned refill address.
- mem_rdata  in  WIDTH  refill data beat.
- mem_rvalid  in  1  beat valid; beats arrive in order, word 0 first.
- hit_count  out  32  number of hits.
- miss_count  out  32  number of misses.

Behaviour:
- Address split: offset = PCF[$clog2(WORDS)+1:2]; index = next $clog2(LINES) bits; tag = remaining upper bits.
- Storage: valid[LINES] (flops), tag[LINES], data[LINES][WORDS].
- Reset (rst=0, asynchronous):
  - all valid bits = 0, FSM = IDLE, beat counter = 0.
  - mem_req = 0, mem_addr = 0, hit_count = miss_count = 0.
  - Outputs are then combinational: hit = 0; stall = req.
- Lookup is combinational: hit = req && valid[idx] && tag[idx]==tag && state==IDLE.
  - InstrF = data[idx][offset] whenever state==IDLE; otherwise 0.
- stall = (req && !hit) || state != IDLE.
- FSM states:
  - IDLE: on req && !hit at a clock edge:
    - latch tag/idx into refill registers;
    - mem_addr <= {tag, idx, zeros};
    - mem_req <= 1 for exactly one cycle;
    - valid[idx] <= 0; beat counter <= 0; miss_count++;
    - go to REFILL.
  - IDLE with req && hit: hit_count++, stay in IDLE.
  - REFILL: PCF and req are ignored; mem_addr is held stable.
    - Each mem_rvalid writes mem_rdata into data[latched idx][beat] and increments the beat counter.
    - On beat WORDS-1: write tag[idx]; set valid[idx]=1 unless an invalidate occurred during this refill; go to IDLE.
- Latency:
  - miss -> next-cycle mem_req -> N memory cycles -> IDLE.
  - The following cycle re-looks-up and hits, so a miss costs at least WORDS+2 cycles.
- inv:
  - In IDLE: all valid bits cleared at the edge; the lookup in that same cycle still uses pre-clear state.
  - In REFILL: clears all valid bits, sets an inv_pending flag, and beats are still consumed. The line is not validated at the end; the flag clears on return to IDLE.
- inv and miss in the same IDLE cycle: refill starts, and the new line is validated on completion (inv precedes the refill).
- req dropping mid-refill: the refill completes normally.
- Counters: 32-bit, wrap from 0xFFFFFFFF to 0. No counting in REFILL or when req=0.
- mem_rvalid while in IDLE: ignored.
- Reset asserted mid-refill: immediate return to IDLE with all lines invalid; remaining beats from memory are ignored.

Test Plan:
1. Cold miss:
   - Stimulus: after reset, req=1, PCF=0x00000010.
   - Required: stall=1, hit=0. Next cycle mem_req=1 (single cycle), mem_addr=0x00000010.
   - Feed 4 beats 0xA0..0xA3.
   - Then: state IDLE, hit=1, InstrF=0xA0, stall=0, miss_count=1.
2. Spatial hit:
   - After scenario 1, PCF=0x14, 0x18, 0x1C on consecutive cycles.
   - Required: hit=1 each cycle; InstrF=0xA1, 0xA2, 0xA3; hit_count increments by 3; no mem_req.
3. Conflict eviction:
   - PCF=0x00000110 (same index, different tag).
   - Required: miss, mem_addr=0x110. After refill with 0xB0..0xB3, InstrF=0xB0.
   - Return to PCF=0x10: miss again.
4. Invalidate during refill:
   - Assert inv for 1 cycle after beat 1 of a refill for PCF=0x20.
   - Required: all 4 beats consumed; return to IDLE with valid[2]=0.
   - Next lookup of 0x20 misses; 0x10 also misses.
5. Stalled beats:
   - mem_rvalid given with gaps (pattern 1,0,0,1,1,0,1).
   - Required: exactly 4 words written in order; stall held high throughout.
   - PCF change to 0x40 mid-refill is ignored; mem_addr stays 0x20.
6. Reset mid-refill and counter wrap:
   - Assert rst=0 after beat 2.
   - Required: asynchronously mem_req=0, mem_addr=0, counters=0; 0x20 then misses.
   - Force hit_count=0xFFFFFFFF via a hit; next hit yields 0.
